pwm_hbridge_driver: RTL

- Parametrised successor to the 4-channel PID-to-PWM stage.
- Converts signed PID outputs, arriving one channel per beat, into H-bridge IN1/IN2 drive for NUM_CHN motors.
- Adds command saturation, a deadband, per-period slew limiting and glitch-free shadow-threshold updates.
- Adds a per-channel direction FSM that inserts dead time on reversal, plus selectable coast or brake stop.
- Sits between the PID core and the motor driver pins.

---
 rtl/pwm_drv_pkg.sv | 37 +++
 rtl/pwm_chan_ctrl.sv | 195 +++++++++++++++++++
 rtl/pwm_hbridge_driver.sv | 82 ++++++++
 3 files changed

// File: rtl/pwm_drv_pkg.sv
// Shared definitions for the PWM H-bridge driver: channel FSM encoding,
// derived timing constants and the width helper.
package pwm_drv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FWD  = 3'd1,
        REV  = 3'd2,
        DEAD = 3'd3,
        STOP = 3'd4
    } chan_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

    function automatic int calc_period(input int clk_freq, input int pwm_freq);
        return clk_freq / pwm_freq - 1;
    endfunction

    function automatic int calc_thr(input int pct, input int period);
        return pct * (period + 1) / 100;
    endfunction

    localparam int PWM_PERIOD = calc_period(27_000_000, 27_000);
    localparam int THR_MIN    = calc_thr(20, PWM_PERIOD);
    localparam int THR_MAX    = calc_thr(80, PWM_PERIOD);

endpackage

// File: rtl/pwm_chan_ctrl.sv
// One motor channel: command capture, magnitude/threshold pipeline, slew-limited
// shadow threshold, direction FSM with dead time, and registered bridge outputs.
module pwm_chan_ctrl
    import pwm_drv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_W       = 10,
    parameter int THR_LO      = 200,
    parameter int THR_HI      = 800,
    parameter int CMD_MAX     = 1024,
    parameter int DEADBAND    = 8,
    parameter int DEAD_CYCLES = 27,
    parameter int SLEW_STEP   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat_en,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic [CNT_W-1:0]      cnt,
    input  logic                  wrap,
    input  logic                  stop,
    input  logic                  brake_mode,
    output logic                  in1,
    output logic                  in2,
    output logic                  busy
);

    localparam int PROD_W = DATA_WIDTH + clog2(THR_HI);
    localparam int DEAD_W = clog2(DEAD_CYCLES + 1);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAG_POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MAG_CLAMP   = DATA_WIDTH'(CMD_MAX);
    localparam logic [DATA_WIDTH-1:0] MAG_DB      = DATA_WIDTH'(DEADBAND);
    localparam logic [CNT_W-1:0]      STEP        = CNT_W'(SLEW_STEP);

    logic [DATA_WIDTH-1:0] cmd;
    logic [DATA_WIDTH-1:0] abs_v;
    logic [DATA_WIDTH-1:0] mag_v;
    logic [DATA_WIDTH-1:0] mag;
    logic                  sign_m;
    logic [PROD_W-1:0]     prod;
    logic [CNT_W-1:0]      target_v;
    logic [CNT_W-1:0]      target;
    logic                  sign_t;
    logic [CNT_W-1:0]      active;
    logic [CNT_W-1:0]      slew_v;
    logic                  hold_zero;
    chan_state_t           state;
    chan_state_t           state_nxt;
    logic [DEAD_W-1:0]     dead_cnt;
    logic [DEAD_W-1:0]     dead_nxt;

    // The most-negative command has no positive twin, so it saturates first.
    always_comb begin
        abs_v = cmd;
        if (cmd == MOST_NEG) begin
            abs_v = MAG_POS_MAX;
        end else if (cmd[DATA_WIDTH-1]) begin
            abs_v = (~cmd) + DATA_WIDTH'(1);
        end
        mag_v = abs_v;
        if (abs_v > MAG_CLAMP) begin
            mag_v = MAG_CLAMP;
        end
        if (abs_v < MAG_DB) begin
            mag_v = '0;
        end
    end

    always_comb begin
        prod     = PROD_W'(mag) * PROD_W'(THR_HI - THR_LO);
        target_v = '0;
        if (mag != '0) begin
            target_v = CNT_W'(THR_LO) + CNT_W'(prod / PROD_W'(CMD_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd    <= '0;
            mag    <= '0;
            sign_m <= 1'b0;
            target <= '0;
            sign_t <= 1'b0;
        end else begin
            if (beat_en) begin
                cmd <= beat_data;
            end
            mag    <= mag_v;
            sign_m <= cmd[DATA_WIDTH-1];
            target <= target_v;
            sign_t <= sign_m;
        end
    end

    // Candidate threshold for the next wrap; never steps past the target.
    always_comb begin
        slew_v = active;
        if (SLEW_STEP == 0) begin
            slew_v = target;
        end else if (target > active) begin
            slew_v = ((target - active) > STEP) ? active + STEP : target;
        end else if (active > target) begin
            slew_v = ((active - target) > STEP) ? active - STEP : target;
        end
    end

    always_comb begin
        state_nxt = state;
        dead_nxt  = dead_cnt;
        unique case (state)
            IDLE: begin
                if (wrap && (slew_v != '0)) begin
                    state_nxt = sign_t ? REV : FWD;
                end
            end
            FWD: begin
                if (sign_t) begin
                    state_nxt = DEAD;
                    dead_nxt  = DEAD_W'(DEAD_CYCLES - 1);
                end else if (wrap && (slew_v == '0)) begin
                    state_nxt = IDLE;
                end
            end
            REV: begin
                if (!sign_t) begin
                    state_nxt = DEAD;
                    dead_nxt  = DEAD_W'(DEAD_CYCLES - 1);
                end else if (wrap && (slew_v == '0)) begin
                    state_nxt = IDLE;
                end
            end
            DEAD: begin
                if (dead_cnt == '0) begin
                    if (target == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = sign_t ? REV : FWD;
                    end
                end else begin
                    dead_nxt = dead_cnt - DEAD_W'(1);
                end
            end
            STOP: begin
                if (!stop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (stop) begin
            state_nxt = STOP;
        end
        hold_zero = (state_nxt == DEAD) || (state_nxt == STOP) || (state == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dead_cnt <= '0;
            active   <= '0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            if (hold_zero) begin
                active <= '0;
            end else if (wrap) begin
                active <= slew_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in1  <= 1'b0;
            in2  <= 1'b0;
            busy <= 1'b0;
        end else begin
            in1  <= 1'b0;
            in2  <= 1'b0;
            busy <= (state == DEAD);
            unique case (state)
                FWD:     in1 <= (cnt < active);
                REV:     in2 <= (cnt < active);
                STOP: begin
                    in1 <= brake_mode;
                    in2 <= brake_mode;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pwm_hbridge_driver.sv
// Multi-channel PID-to-H-bridge PWM driver: shared period counter, beat
// address decode, and one pwm_chan_ctrl per motor.
module pwm_hbridge_driver
    import pwm_drv_pkg::*;
#(
    parameter int NUM_CHN      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int CHN_WIDTH    = 3,
    parameter int CLK_FREQ     = 27_000_000,
    parameter int PWM_FREQ     = 27_000,
    parameter int DUTY_MIN_PCT = 20,
    parameter int DUTY_MAX_PCT = 80,
    parameter int CMD_MAX      = 1024,
    parameter int DEADBAND     = 8,
    parameter int DEAD_CYCLES  = 27,
    parameter int SLEW_STEP    = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  u_valid,
    input  logic [CHN_WIDTH-1:0]  u_chn,
    input  logic [DATA_WIDTH-1:0] u_data,
    input  logic [NUM_CHN-1:0]    stop,
    input  logic                  brake_mode,
    output logic [NUM_CHN-1:0]    motor_in1,
    output logic [NUM_CHN-1:0]    motor_in2,
    output logic                  period_start,
    output logic [NUM_CHN-1:0]    dir_busy
);

    localparam int CNT_MAX = calc_period(CLK_FREQ, PWM_FREQ);
    localparam int THR_LO  = calc_thr(DUTY_MIN_PCT, CNT_MAX);
    localparam int THR_HI  = calc_thr(DUTY_MAX_PCT, CNT_MAX);
    // One extra code so a 100% threshold still fits beside the counter.
    localparam int CNT_W   = clog2(CNT_MAX + 2);

    logic [CNT_W-1:0]   cnt;
    logic               wrap;
    logic               chn_ok;
    logic [NUM_CHN-1:0] beat_en;

    assign wrap   = (cnt == CNT_W'(CNT_MAX));
    assign chn_ok = (int'(u_chn) < NUM_CHN);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= wrap ? '0 : cnt + CNT_W'(1);
            period_start <= (cnt == '0);
        end
    end

    for (genvar g = 0; g < NUM_CHN; g++) begin : g_chan
        assign beat_en[g] = u_valid && chn_ok && (u_chn == CHN_WIDTH'(g));

        pwm_chan_ctrl #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_W      (CNT_W),
            .THR_LO     (THR_LO),
            .THR_HI     (THR_HI),
            .CMD_MAX    (CMD_MAX),
            .DEADBAND   (DEADBAND),
            .DEAD_CYCLES(DEAD_CYCLES),
            .SLEW_STEP  (SLEW_STEP)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .beat_en   (beat_en[g]),
            .beat_data (u_data),
            .cnt       (cnt),
            .wrap      (wrap),
            .stop      (stop[g]),
            .brake_mode(brake_mode),
            .in1       (motor_in1[g]),
            .in2       (motor_in2[g]),
            .busy      (dir_busy[g])
        );
    end

endmodule
